// File: rtl/mcpu_core_fetch_pkg.sv
// mcpu_core_fetch_pkg: shared types and constants for the fetch queue.
// Rev 1.0
`default_nettype none

package mcpu_core_fetch_pkg;

    typedef enum logic [0:0] {
        FQ_RUN  = 1'b0,
        FQ_HALT = 1'b1
    } fq_state_e;

    // Per-entry status; the entry's pc and data live in parallel arrays
    // so their widths can follow the module parameters.
    typedef struct packed {
        logic valid;
        logic filled;
        logic stale;
        logic fault;
    } fq_flags_t;

    localparam int unsigned FQ_DEPTH_DEFAULT = 4;

    function automatic int unsigned fq_ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    localparam int unsigned FQ_PTR_W = fq_ptr_w(FQ_DEPTH_DEFAULT);

endpackage

`default_nettype wire

// File: rtl/mcpu_core_fetch_trackq.sv
// mcpu_core_fetch_trackq: in-order tracking queue of outstanding and returned I$ packets.
// Rev 1.0
`default_nettype none

module mcpu_core_fetch_trackq
    import mcpu_core_fetch_pkg::*;
#(
    parameter int unsigned VADDR_W = 28,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned DEPTH   = FQ_DEPTH_DEFAULT
) (
    input  logic               clkrst_core_clk,
    input  logic               clkrst_core_rst,
    input  logic               alloc_i,
    input  logic [VADDR_W-1:0] alloc_pc_i,
    input  logic               rsp_valid_i,
    input  logic [DATA_W-1:0]  rsp_data_i,
    input  logic               rsp_fault_i,
    input  logic               flush_i,
    input  logic               pop_ready_i,
    output logic               head_valid_o,
    output logic [VADDR_W-1:0] head_pc_o,
    output logic [DATA_W-1:0]  head_data_o,
    output logic               head_fault_o,
    output logic               pop_o,
    output logic               full_o
);

    localparam int unsigned PTR_W = fq_ptr_w(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fq_flags_t          flags_q [DEPTH];
    fq_flags_t          flags_d [DEPTH];
    logic [VADDR_W-1:0] pc_q    [DEPTH];
    logic [DATA_W-1:0]  data_q  [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] nout_q, nout_d;

    fq_flags_t head_flags;
    logic      w_drop;
    logic      w_alloc;
    logic      w_fill;
    logic      w_pop;

    assign head_flags   = flags_q[head_q];
    assign head_valid_o = head_flags.valid & head_flags.filled & ~head_flags.stale;
    assign head_pc_o    = pc_q[head_q];
    assign head_data_o  = data_q[head_q];
    assign head_fault_o = head_flags.fault;
    assign full_o       = (count_q == CNT_W'(DEPTH));

    // Stale packets at the head retire silently, sharing the single pop slot.
    assign w_drop  = head_flags.valid & head_flags.filled & head_flags.stale;
    assign pop_o   = head_valid_o & pop_ready_i & ~flush_i;
    assign w_pop   = (pop_o | w_drop) & ~flush_i;
    assign w_alloc = alloc_i & ~flush_i & ~full_o;
    assign w_fill  = rsp_valid_i & (nout_q != '0);

    always_comb begin
        flags_d = flags_q;
        head_d  = head_q;
        tail_d  = tail_q;
        fill_d  = fill_q;
        count_d = count_q;
        nout_d  = nout_q + CNT_W'(w_alloc) - CNT_W'(w_fill);

        if (w_fill) begin
            flags_d[fill_q].filled = 1'b1;
            flags_d[fill_q].fault  = rsp_fault_i;
            fill_d                 = fill_q + 1'b1;
        end

        if (flush_i) begin
            // Filled entries vanish; unfilled ones stay as stale placeholders
            // until their responses come back, so head jumps to the fill pointer.
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (flags_q[i].valid) begin
                    if (flags_q[i].filled) begin
                        flags_d[i].valid = 1'b0;
                    end else begin
                        flags_d[i].stale = 1'b1;
                    end
                end
            end
            head_d  = fill_q;
            count_d = nout_q;
        end else begin
            if (w_alloc) begin
                flags_d[tail_q].valid  = 1'b1;
                flags_d[tail_q].filled = 1'b0;
                flags_d[tail_q].stale  = 1'b0;
                flags_d[tail_q].fault  = 1'b0;
                tail_d                 = tail_q + 1'b1;
            end
            if (w_pop) begin
                flags_d[head_q].valid = 1'b0;
                head_d                = head_q + 1'b1;
            end
            count_d = count_q + CNT_W'(w_alloc) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                flags_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
            nout_q  <= '0;
        end else begin
            flags_q <= flags_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            fill_q  <= fill_d;
            count_q <= count_d;
            nout_q  <= nout_d;
        end
    end

    always_ff @(posedge clkrst_core_clk) begin
        if (w_alloc) begin
            pc_q[tail_q] <= alloc_pc_i;
        end
        if (w_fill) begin
            data_q[fill_q] <= rsp_data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mcpu_core_fetch_queue.sv
// mcpu_core_fetch_queue: sequential PC generator with multiple outstanding I$ requests.
// Rev 1.0
`default_nettype none

module mcpu_core_fetch_queue
    import mcpu_core_fetch_pkg::*;
#(
    parameter int unsigned        VADDR_W  = 28,
    parameter int unsigned        DATA_W   = 128,
    parameter int unsigned        DEPTH    = FQ_DEPTH_DEFAULT,
    parameter logic [VADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clkrst_core_clk,
    input  logic               clkrst_core_rst,
    input  logic               fetch_en,
    input  logic               pipe_flush,
    input  logic [VADDR_W-1:0] pc2f_newpc,
    output logic               f2ic_valid,
    output logic [VADDR_W-1:0] f2ic_vaddr,
    input  logic               ic2f_ready,
    input  logic               ic2f_rsp_valid,
    input  logic [DATA_W-1:0]  ic2f_rsp_data,
    input  logic               ic2f_rsp_fault,
    output logic               f2d_valid,
    input  logic               f2d_ready,
    output logic [VADDR_W-1:0] f2d_virtpc,
    output logic [DATA_W-1:0]  f2d_data,
    output logic               f2d_fault,
    output logic               f_halted
);

    fq_state_e          state_q, state_d;
    logic [VADDR_W-1:0] pc_q, pc_d;

    logic w_full;
    logic w_issue;
    logic w_pop;
    logic w_head_fault;

    assign f2ic_valid = fetch_en & (state_q == FQ_RUN) & ~w_full & ~pipe_flush;
    assign f2ic_vaddr = pc_q;
    assign w_issue    = f2ic_valid & ic2f_ready;
    assign f2d_fault  = w_head_fault;
    assign f_halted   = (state_q == FQ_HALT);

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        if (pipe_flush) begin
            pc_d = pc2f_newpc;
        end else if (w_issue) begin
            pc_d = pc_q + 1'b1;
        end
        case (state_q)
            FQ_RUN: begin
                if (!pipe_flush && w_pop && w_head_fault) begin
                    state_d = FQ_HALT;
                end
            end
            FQ_HALT: begin
                if (pipe_flush) begin
                    state_d = FQ_RUN;
                end
            end
            default: state_d = FQ_RUN;
        endcase
    end

    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            state_q <= FQ_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    mcpu_core_fetch_trackq #(
        .VADDR_W (VADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH)
    ) u_trackq (
        .clkrst_core_clk (clkrst_core_clk),
        .clkrst_core_rst (clkrst_core_rst),
        .alloc_i         (w_issue),
        .alloc_pc_i      (pc_q),
        .rsp_valid_i     (ic2f_rsp_valid),
        .rsp_data_i      (ic2f_rsp_data),
        .rsp_fault_i     (ic2f_rsp_fault),
        .flush_i         (pipe_flush),
        .pop_ready_i     (f2d_ready),
        .head_valid_o    (f2d_valid),
        .head_pc_o       (f2d_virtpc),
        .head_data_o     (f2d_data),
        .head_fault_o    (w_head_fault),
        .pop_o           (w_pop),
        .full_o          (w_full)
    );

endmodule

`default_nettype wire

// File: tb/tb_mcpu_core_fetch_queue.sv
// tb_mcpu_core_fetch_queue: randomized scoreboard bench with an I$ model and directed scenarios.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_mcpu_core_fetch_queue;

    localparam int          VW    = 12;
    localparam int          DW    = 128;
    localparam int          DEPTH = 4;
    localparam logic [VW-1:0] RPC = 12'hFFE;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fetch_en = 1'b0;
    logic          pipe_flush = 1'b0;
    logic [VW-1:0] pc2f_newpc = '0;
    logic          f2ic_valid;
    logic [VW-1:0] f2ic_vaddr;
    logic          ic2f_ready = 1'b0;
    logic          ic2f_rsp_valid = 1'b0;
    logic [DW-1:0] ic2f_rsp_data = '0;
    logic          ic2f_rsp_fault = 1'b0;
    logic          f2d_valid;
    logic          f2d_ready = 1'b0;
    logic [VW-1:0] f2d_virtpc;
    logic [DW-1:0] f2d_data;
    logic          f2d_fault;
    logic          f_halted;

    always #5 clk = ~clk;

    mcpu_core_fetch_queue #(
        .VADDR_W  (VW),
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .clkrst_core_clk (clk),
        .clkrst_core_rst (rst),
        .fetch_en        (fetch_en),
        .pipe_flush      (pipe_flush),
        .pc2f_newpc      (pc2f_newpc),
        .f2ic_valid      (f2ic_valid),
        .f2ic_vaddr      (f2ic_vaddr),
        .ic2f_ready      (ic2f_ready),
        .ic2f_rsp_valid  (ic2f_rsp_valid),
        .ic2f_rsp_data   (ic2f_rsp_data),
        .ic2f_rsp_fault  (ic2f_rsp_fault),
        .f2d_valid       (f2d_valid),
        .f2d_ready       (f2d_ready),
        .f2d_virtpc      (f2d_virtpc),
        .f2d_data        (f2d_data),
        .f2d_fault       (f2d_fault),
        .f_halted        (f_halted)
    );

    typedef struct { logic [VW-1:0] pc; logic [DW-1:0] data; logic fault; } pkt_t;
    typedef struct { logic [VW-1:0] pc; int due; int epoch; } req_t;

    pkt_t exp_q[$];
    req_t pend_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int epoch = 0;
    logic [VW-1:0] pc_m = RPC;
    bit  halted_m = 1'b0;
    int  issued_cnt = 0;
    int  pop_cnt = 0;
    logic [VW-1:0] first_pop_pc = '0;
    logic [VW-1:0] fault_pop_pc = '0;

    int k_fe = 0, k_icr = 100, k_dr = 100, k_lat_min = 2, k_lat_max = 2;
    int k_rsp = 100, k_flush = 0, k_fault = 0;
    bit d_flush = 1'b0;
    logic [VW-1:0] d_newpc = '0;
    bit fault_arm = 1'b0;
    logic [VW-1:0] fault_pc = '0;

    function automatic void check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void fail(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endfunction

    function automatic bit roll(input int pct);
        return int'($urandom_range(99, 0)) < pct;
    endfunction

    // One clock of I$ model + reference model; returns just before the rising edge.
    task automatic cycle();
        int due;
        @(negedge clk);
        cyc++;
        fetch_en    = roll(k_fe);
        ic2f_ready  = roll(k_icr);
        f2d_ready   = roll(k_dr);
        pipe_flush  = d_flush | roll(k_flush);
        pc2f_newpc  = d_flush ? d_newpc : VW'($urandom());
        d_flush     = 1'b0;
        ic2f_rsp_valid = 1'b0;
        ic2f_rsp_fault = 1'b0;
        ic2f_rsp_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (pend_q.size() > 0 && pend_q[0].due <= cyc && roll(k_rsp)) begin
            ic2f_rsp_valid = 1'b1;
            ic2f_rsp_fault = (fault_arm && pend_q[0].pc == fault_pc) || roll(k_fault);
        end
        #1;
        if (ic2f_rsp_valid) begin
            assert (pend_q.size() > 0) else $error("I$ response without a matching request");
            if (pend_q[0].epoch == epoch && !pipe_flush)
                exp_q.push_back('{pend_q[0].pc, ic2f_rsp_data, ic2f_rsp_fault});
            void'(pend_q.pop_front());
        end
        if (pipe_flush) begin
            epoch++;
            exp_q.delete();
            pc_m = pc2f_newpc;
        end
        if (f2ic_valid && ic2f_ready) begin
            check("issue_addr", DW'(f2ic_vaddr), DW'(pc_m));
            issued_cnt++;
            due = cyc + int'($urandom_range(k_lat_max, k_lat_min));
            if (pend_q.size() > 0 && pend_q[$].due > due) due = pend_q[$].due;
            pend_q.push_back('{pc_m, due, epoch});
            pc_m = pc_m + 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        fetch_en = 1'b0; pipe_flush = 1'b0; ic2f_rsp_valid = 1'b0;
        ic2f_ready = 1'b0; f2d_ready = 1'b0;
        pend_q.delete();
        exp_q.delete();
        epoch++;
        pc_m = RPC;
        repeat (2) @(negedge clk);
        #1;
        check("rst_f2ic_valid", DW'(f2ic_valid), '0);
        check("rst_f2d_valid", DW'(f2d_valid), '0);
        check("rst_halted", DW'(f_halted), '0);
        check("rst_vaddr", DW'(f2ic_vaddr), DW'(RPC));
        rst = 1'b0;
    endtask

    task automatic set_knobs(input int fe, input int icr, input int dr, input int lmin,
                             input int lmax, input int rsp, input int fl, input int flt);
        k_fe = fe; k_icr = icr; k_dr = dr; k_lat_min = lmin; k_lat_max = lmax;
        k_rsp = rsp; k_flush = fl; k_fault = flt;
    endtask

    task automatic drain();
        int n = 0;
        set_knobs(0, 100, 100, 1, 3, 100, 0, 0);
        while ((pend_q.size() > 0 || exp_q.size() > 0) && n < 200) begin
            cycle();
            n++;
        end
        if (n >= 200) fail("drain_timeout");
        repeat (DEPTH + 2) cycle();
    endtask

    task automatic flush_to(input logic [VW-1:0] npc);
        d_flush = 1'b1;
        d_newpc = npc;
        cycle();
    endtask

    // Monitor: compares presented packets against the scoreboard and tracks halt.
    initial begin
        pkt_t p;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                halted_m = 1'b0;
            end else begin
                check("halted", DW'(f_halted), DW'(halted_m));
                if (halted_m || pipe_flush || !fetch_en)
                    check("issue_gate", DW'(f2ic_valid), '0);
                if (!pipe_flush && f2d_valid) begin
                    if (exp_q.size() == 0) begin
                        fail("f2d_spurious");
                    end else if (f2d_ready) begin
                        p = exp_q.pop_front();
                        check("f2d_pc", DW'(f2d_virtpc), DW'(p.pc));
                        check("f2d_data", f2d_data, p.data);
                        check("f2d_fault", DW'(f2d_fault), DW'(p.fault));
                        if (pop_cnt == 0) first_pop_pc = p.pc;
                        pop_cnt++;
                        if (p.fault) begin
                            halted_m = 1'b1;
                            fault_pop_pc = p.pc;
                        end
                    end
                end
                if (pipe_flush) halted_m = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Streaming from RESET_PC, crossing the 12-bit wrap point.
        set_knobs(100, 100, 100, 2, 2, 100, 0, 0);
        pop_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (i >= 6) begin
                check("stream_issue", DW'(f2ic_valid), DW'(1'b1));
                check("stream_out", DW'(f2d_valid), DW'(1'b1));
            end
        end
        check("stream_first_pc", DW'(first_pop_pc), DW'(RPC));

        // Backpressure: exactly DEPTH requests, then in-order drain and resume.
        drain();
        flush_to(12'h020);
        set_knobs(100, 100, 0, 2, 2, 100, 0, 0);
        issued_cnt = 0;
        repeat (12) cycle();
        check("bp_issued", DW'(issued_cnt), DW'(DEPTH));
        check("bp_blocked", DW'(f2ic_valid), '0);
        pop_cnt = 0;
        k_dr = 100;
        repeat (20) cycle();
        check("bp_first_pc", DW'(first_pop_pc), DW'(12'h020));

        // Flush with three requests in flight.
        drain();
        flush_to(12'h005);
        set_knobs(100, 100, 100, 6, 6, 100, 0, 0);
        repeat (3) cycle();
        k_fe = 0;
        flush_to(12'h100);
        pop_cnt = 0;
        set_knobs(100, 100, 100, 2, 2, 100, 0, 0);
        repeat (20) cycle();
        check("inflight_first_pc", DW'(first_pop_pc), DW'(12'h100));

        // Fault on PC 9 halts fetch until the next flush.
        drain();
        flush_to(12'h009);
        set_knobs(100, 100, 100, 2, 2, 100, 0, 0);
        fault_arm = 1'b1;
        fault_pc  = 12'h009;
        repeat (15) cycle();
        check("fault_halted", DW'(f_halted), DW'(1'b1));
        check("fault_pc", DW'(fault_pop_pc), DW'(12'h009));
        fault_arm = 1'b0;
        drain();
        k_fe = 100;
        flush_to(12'h040);
        pop_cnt = 0;
        cycle();
        check("unhalt", DW'(f_halted), '0);
        repeat (10) cycle();
        check("resume_first_pc", DW'(first_pop_pc), DW'(12'h040));

        // Flush coinciding with a response arrival and a ready pop.
        drain();
        set_knobs(100, 100, 100, 2, 2, 100, 0, 0);
        repeat (10) cycle();
        flush_to(12'h200);
        check("simul_present", DW'(f2d_valid & ic2f_rsp_valid), DW'(1'b1));
        pop_cnt = 0;
        repeat (15) cycle();
        check("simul_first_pc", DW'(first_pop_pc), DW'(12'h200));

        // Randomized traffic, then a mid-operation reset.
        set_knobs(80, 70, 70, 1, 5, 80, 4, 3);
        repeat (3000) cycle();
        do_reset();
        set_knobs(100, 100, 100, 1, 4, 90, 0, 0);
        pop_cnt = 0;
        repeat (30) cycle();
        check("post_rst_first_pc", DW'(first_pop_pc), DW'(RPC));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
